wb_write_queue: RTL and testbench

//  Write-side companion of the register file. Buffers writeback results (dest, value)

---
 rtl/wb_write_queue_pkg.sv | 14 +
 rtl/wb_bypass_match.sv | 33 +++
 rtl/wb_write_queue.sv | 100 ++++++++++
 tb/tb_wb_write_queue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wb_write_queue_pkg.sv
// Shared widths and the queued writeback entry type for the regfile write queue.
package wb_write_queue_pkg;

    localparam int unsigned WORD_LEN          = 32;
    localparam int unsigned REG_FILE_ADDR_LEN = 5;
    localparam logic [REG_FILE_ADDR_LEN-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                         valid;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic [WORD_LEN-1:0]          val;
    } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-first match of one ID-stage source address against pending queue entries.
module wb_bypass_match
    import wb_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]           entries,
    input  logic [$clog2(DEPTH)-1:0]        head,
    input  logic [REG_FILE_ADDR_LEN-1:0]    src,
    output logic                            hit,
    output logic [WORD_LEN-1:0]             val
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Valid entries are contiguous from head, so walking oldest->youngest and
    // letting later matches overwrite leaves the youngest match.
    always_comb begin
        hit = 1'b0;
        val = '0;
        idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = PTR_W'(32'(head) + k);
            if (entries[idx].valid && entries[idx].dest == src && src != REG_ZERO) begin
                hit = 1'b1;
                val = entries[idx].val;
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the regfile write port, with two bypass lookups.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [REG_FILE_ADDR_LEN-1:0]    in_dest,
    input  logic [WORD_LEN-1:0]             in_val,
    output logic                            in_ready,
    input  logic                            rf_ready,
    output logic [REG_FILE_ADDR_LEN-1:0]    rf_dest,
    output logic [WORD_LEN-1:0]             rf_val,
    output logic                            rf_en,
    input  logic [REG_FILE_ADDR_LEN-1:0]    src1,
    input  logic [REG_FILE_ADDR_LEN-1:0]    src2,
    output logic                            byp1_hit,
    output logic [WORD_LEN-1:0]             byp1_val,
    output logic                            byp2_hit,
    output logic [WORD_LEN-1:0]             byp2_val,
    output logic [$clog2(DEPTH):0]          count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic empty, full, push, pop;

    always_comb begin
        empty    = (count_q == CNT_W'(0));
        full     = (count_q == CNT_W'(DEPTH));
        pop      = !empty && rf_ready;
        in_ready = !full || pop;
        // r0 writes complete the handshake but are dropped.
        push     = in_valid && in_ready && (in_dest != REG_ZERO);
    end

    // Pop is applied before push so a full-queue push+pop reusing the head slot lands.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PTR_W'(1);
        end
        if (push) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].dest  = in_dest;
            entries_d[tail_q].val   = in_val;
            tail_d                  = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        rf_en   = !empty;
        rf_dest = entries_q[head_q].dest;
        rf_val  = entries_q[head_q].val;
        count   = count_q;
    end

    wb_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
        .entries (entries_q),
        .head    (head_q),
        .src     (src1),
        .hit     (byp1_hit),
        .val     (byp1_val)
    );

    wb_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
        .entries (entries_q),
        .head    (head_q),
        .src     (src2),
        .hit     (byp2_hit),
        .val     (byp2_val)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized and directed bench for wb_write_queue against a queue-based reference model.
module tb_wb_write_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_dest;
    logic [31:0] in_val;
    logic        in_ready;
    logic        rf_ready;
    logic [4:0]  rf_dest;
    logic [31:0] rf_val;
    logic        rf_en;
    logic [4:0]  src1, src2;
    logic        byp1_hit, byp2_hit;
    logic [31:0] byp1_val, byp2_val;
    logic [2:0]  count;

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_dest(in_dest), .in_val(in_val), .in_ready(in_ready),
        .rf_ready(rf_ready), .rf_dest(rf_dest), .rf_val(rf_val), .rf_en(rf_en),
        .src1(src1), .src2(src2),
        .byp1_hit(byp1_hit), .byp1_val(byp1_val),
        .byp2_hit(byp2_hit), .byp2_val(byp2_val),
        .count(count)
    );

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_byp(input logic [4:0] s, output logic h, output logic [31:0] v);
        h = 1'b0;
        v = '0;
        if (s != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].d == s) begin
                    h = 1'b1;
                    v = q[i].v;
                    break;
                end
            end
        end
    endfunction

    // One clock: drive at negedge, check combinational view, then advance the model at posedge.
    task automatic step(input logic r, input logic iv, input logic [4:0] d, input logic [31:0] v,
                        input logic rr, input logic [4:0] s1, input logic [4:0] s2);
        logic        e_en, e_rdy, h1, h2;
        logic [31:0] v1, v2;
        ent_t        ne;
        @(negedge clk);
        rst = r; in_valid = iv; in_dest = d; in_val = v; rf_ready = rr; src1 = s1; src2 = s2;
        #1;
        e_en  = (q.size() != 0);
        e_rdy = (q.size() < DEPTH) || (e_en && rr);
        model_byp(s1, h1, v1);
        model_byp(s2, h2, v2);
        chk("count", 32'(count), 32'(q.size()));
        chk("rf_en", 32'(rf_en), 32'(e_en));
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        if (e_en) begin
            chk("rf_dest", 32'(rf_dest), 32'(q[0].d));
            chk("rf_val", rf_val, q[0].v);
        end
        chk("byp1_hit", 32'(byp1_hit), 32'(h1));
        chk("byp2_hit", 32'(byp2_hit), 32'(h2));
        if (h1) chk("byp1_val", byp1_val, v1);
        if (h2) chk("byp2_val", byp2_val, v2);
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (e_en && rr) begin
                void'(q.pop_front());
                n_writes++;
            end
            if (iv && e_rdy && d != 5'd0) begin
                ne.d = d;
                ne.v = v;
                q.push_back(ne);
            end
        end
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, 5'd0, 32'd0, rr, 5'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_val = '0; rf_ready = 1'b1; src1 = '0; src2 = '0;
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        idle(1'b1);

        // Single push reaches rf one cycle later, then drains
        step(1'b0, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 5'd0);
        #1;
        chk("t1_rf_en", 32'(rf_en), 32'd1);
        chk("t1_rf_dest", 32'(rf_dest), 32'd3);
        chk("t1_rf_val", rf_val, 32'hAA);
        idle(1'b1);
        idle(1'b1);

        // Fill with regfile stalled, hold 5th, then push+pop while full
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 5'(i + 1), 32'(32'h100 + i), 1'b0, 5'd2, 5'd4);
        #1;
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        step(1'b0, 1'b1, 5'd9, 32'h900, 1'b0, 5'd9, 5'd1);
        step(1'b0, 1'b1, 5'd9, 32'h900, 1'b1, 5'd9, 5'd1);
        #1;
        chk("t3_count_stays", 32'(count), 32'd4);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Same-dest pending writes: youngest bypassed, oldest drains first
        step(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd5, 5'd0);
        step(1'b0, 1'b1, 5'd5, 32'h22, 1'b0, 5'd5, 5'd0);
        #1;
        chk("t4_byp1_hit", 32'(byp1_hit), 32'd1);
        chk("t4_byp1_val", byp1_val, 32'h22);
        chk("t4_rf_val_old", rf_val, 32'h11);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
        #1;
        chk("t4_rf_val_new", rf_val, 32'h22);
        idle(1'b1);

        // r0 write accepted but dropped
        step(1'b0, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 5'd0);
        #1;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_rf_en", 32'(rf_en), 32'd0);
        chk("t5_byp2_hit", 32'(byp2_hit), 32'd0);

        // Reset with pending writes discards them
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'(i + 10), 32'(32'hC0 + i), 1'b0, 5'd10, 5'd11);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd10, 5'd11);
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_rf_en", 32'(rf_en), 32'd0);
        chk("t6_byp1_hit", 32'(byp1_hit), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 7),
                 5'($urandom_range(0, 7)),
                 $urandom,
                 ($urandom_range(0, 9) < 6),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);
        chk("drained", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
